pattern_detector: RTL and testbench
===================================

PATTERN_DETECTOR -- requirements
Module: pattern_detector

Interface
REQ-001 Parameter PATTERN_WIDTH, default 3: pattern length N in bits; legal range 2..16.
REQ-002 Parameter PATTERN, default 3'b101: N-bit pattern; bit N-1 is the first bit received, bit 0 the last.
REQ-003 Parameter OVERLAP, default 1: 1 = overlapping matches allowed; 0 = matching restarts from empty after each match.
REQ-004 Parameter COUNT_WIDTH, default 8: width of match_count; legal range 1..32.
REQ-005 The block has one clock; reset is synchronous and active-high: clock is the sole clock, and clear is the synchronous, active-high reset sampled on the rising edge.
REQ-006 clock  input  1  sole clock; all state updates on the rising edge.
REQ-007 clear  input  1  synchronous active-high reset.
REQ-008 enable  input  1  qualifies d; a bit is consumed only in cycles with enable=1.
REQ-009 d  input  1  serial data bit.
REQ-010 count_clear  input  1  synchronous clear of match_count and saturated.
REQ-011 detect  output  1  registered one-cycle pulse per match.
REQ-012 match_count  output  COUNT_WIDTH  saturating count of matches.
REQ-013 saturated  output  1  sticky flag: match_count reached all-ones.
REQ-014 fill  output  $clog2(N+1)  number of valid history bits, 0..N.

Function
REQ-015 Internal state: N-bit history shift register hist and fill counter.
REQ-016 On an accepted bit (enable=1, clear=0): hist <= {hist[N-2:0], d}; fill <= min(fill+1, N).
REQ-017 Match is true in a cycle when enable=1, fill >= N-1, and {hist[N-2:0], d} == PATTERN.
REQ-018 detect <= match; detect is high for exactly the cycle after the cycle in which the last pattern bit is accepted (latency 1).
REQ-019 detect <= 0 in any cycle with enable=0; hist and fill hold their values.
REQ-020 If OVERLAP=1, a match does not alter the fill update; a later match may reuse bits of the earlier one.
REQ-021 If OVERLAP=0, a match forces fill <= 0, overriding REQ-016; hist still shifts.
REQ-022 No match is possible until N bits have been accepted since clear or since a non-overlap restart, even if the reset-value history equals PATTERN.
REQ-023 match_count increments by 1 on a match and saturates at 2^COUNT_WIDTH-1; it never wraps.
REQ-024 saturated <= 1 when match_count becomes all-ones; it remains set until clear or count_clear.
REQ-025 count_clear without a match sets match_count <= 0 and saturated <= 0.
REQ-026 count_clear with a simultaneous match sets match_count <= 1 and saturated <= (COUNT_WIDTH==1).
REQ-027 count_clear does not affect hist, fill, or detect.
REQ-028 Illegal parameter values cause an elaboration-time error.

Reset
REQ-029 While clear=1: hist <= 0, fill <= 0, detect <= 0, match_count <= 0, saturated <= 0; clear overrides enable and count_clear.
REQ-030 clear mid-pattern discards all partial progress; the first cycle after clear deasserts behaves as if no bits had been received.

Verification (N=3, PATTERN=3'b101 unless stated)
REQ-031 OVERLAP=1, enable=1, d=1,0,1,0,1 -> detect pulses the cycle after bit 3 and after bit 5; match_count=2.
REQ-032 OVERLAP=0, d=1,0,1,0,1,0,1 -> detect after bit 3 and bit 7 only; match_count=2; fill=0 after each match.
REQ-033 d=1, enable=0 for 2 cycles, d=0, enable=0, d=1 -> exactly one detect, the cycle after the final 1; detect=0 throughout the gaps.
REQ-034 d=1,0, then clear for 1 cycle, then d=1 -> no detect; fill=1; following d=0,1 -> detect.
REQ-035 PATTERN=3'b000, d=0,0 after clear -> no detect (fill=2); third d=0 -> detect.
REQ-036 COUNT_WIDTH=2, OVERLAP=1, d=1,0,1,0,1,0,1,0,1 -> match_count=3 and saturated=1 after the 3rd match, still 3 after the 4th; count_clear asserted in the same cycle as a subsequent match -> match_count=1, saturated=0.

Source files
------------

// File: rtl/pattern_detector.sv
// Serial bit-pattern detector: shifts accepted bits into a history window,
// pulses detect one cycle after a full-pattern match and keeps a saturating match count.
module pattern_detector #(
    parameter int                       PATTERN_WIDTH = 3,
    parameter logic [PATTERN_WIDTH-1:0] PATTERN       = 3'b101,
    parameter int                       OVERLAP       = 1,
    parameter int                       COUNT_WIDTH   = 8
) (
    input  logic                                 clock,
    input  logic                                 clear,
    input  logic                                 enable,
    input  logic                                 d,
    input  logic                                 count_clear,
    output logic                                 detect,
    output logic [COUNT_WIDTH-1:0]               match_count,
    output logic                                 saturated,
    output logic [$clog2(PATTERN_WIDTH+1)-1:0]   fill
);

    localparam int FW = $clog2(PATTERN_WIDTH + 1);
    localparam logic [FW-1:0]          FILL_MAX  = FW'(PATTERN_WIDTH);
    localparam logic [FW-1:0]          FILL_ARM  = FW'(PATTERN_WIDTH - 1);
    localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = {COUNT_WIDTH{1'b1}};

    generate
        if (PATTERN_WIDTH < 2 || PATTERN_WIDTH > 16 ||
            COUNT_WIDTH < 1 || COUNT_WIDTH > 32 ||
            (OVERLAP != 0 && OVERLAP != 1)) begin : g_param_check
            $error("pattern_detector: illegal parameter value");
        end
    endgenerate

    // Only the newest N-1 bits are kept: the oldest bit of an N-bit window
    // falls out on the very shift that completes the next window.
    logic [PATTERN_WIDTH-2:0] r_hist;
    logic [FW-1:0]            r_fill;
    logic                     r_detect;
    logic [COUNT_WIDTH-1:0]   r_count;
    logic                     r_sat;

    logic [PATTERN_WIDTH-1:0] w_window;
    logic                     w_match;
    logic [COUNT_WIDTH-1:0]   w_count_inc;

    assign w_window    = {r_hist, d};
    assign w_match     = enable && (r_fill >= FILL_ARM) && (w_window == PATTERN);
    assign w_count_inc = (r_count == COUNT_MAX) ? r_count : r_count + COUNT_WIDTH'(1);

    always_ff @(posedge clock) begin
        if (clear) begin
            r_hist   <= '0;
            r_fill   <= '0;
            r_detect <= 1'b0;
            r_count  <= '0;
            r_sat    <= 1'b0;
        end else begin
            r_detect <= w_match;

            if (enable) begin
                r_hist <= w_window[PATTERN_WIDTH-2:0];
                if (OVERLAP == 0 && w_match) begin
                    r_fill <= '0;
                end else if (r_fill != FILL_MAX) begin
                    r_fill <= r_fill + FW'(1);
                end
            end

            // A match coinciding with count_clear is counted as the first
            // match after the clear rather than being lost.
            if (count_clear) begin
                r_count <= w_match ? COUNT_WIDTH'(1) : '0;
                r_sat   <= w_match && (COUNT_WIDTH == 1);
            end else if (w_match) begin
                r_count <= w_count_inc;
                r_sat   <= r_sat || (w_count_inc == COUNT_MAX);
            end
        end
    end

    assign detect      = r_detect;
    assign match_count = r_count;
    assign saturated   = r_sat;
    assign fill        = r_fill;

endmodule

// File: tb/tb_pattern_detector.sv
// Scoreboard bench: stimulus pushes hand-computed expected state per cycle,
// a monitor pops and compares the selected instance's outputs after each edge.
module tb_pattern_detector;

    logic clk;
    logic clear, enable, d, count_clear;

    logic       det0, det1, det2, det3, det4;
    logic [7:0] cnt0, cnt1, cnt2, cnt4;
    logic [1:0] cnt3;
    logic       sat0, sat1, sat2, sat3, sat4;
    logic [1:0] fill0, fill1, fill2, fill3;
    logic [2:0] fill4;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int    id;
        logic  det;
        int    cnt;
        logic  sat;
        int    fill;
        string tag;
    } exp_t;

    exp_t q[$];

    // 0: 101 overlap; 1: 101 no overlap; 2: 000; 3: 101 with 2-bit count; 4: 4-bit 1100
    pattern_detector #(.PATTERN_WIDTH(3), .PATTERN(3'b101), .OVERLAP(1), .COUNT_WIDTH(8)) u_dut0 (
        .clock(clk), .clear(clear), .enable(enable), .d(d), .count_clear(count_clear),
        .detect(det0), .match_count(cnt0), .saturated(sat0), .fill(fill0));
    pattern_detector #(.PATTERN_WIDTH(3), .PATTERN(3'b101), .OVERLAP(0), .COUNT_WIDTH(8)) u_dut1 (
        .clock(clk), .clear(clear), .enable(enable), .d(d), .count_clear(count_clear),
        .detect(det1), .match_count(cnt1), .saturated(sat1), .fill(fill1));
    pattern_detector #(.PATTERN_WIDTH(3), .PATTERN(3'b000), .OVERLAP(1), .COUNT_WIDTH(8)) u_dut2 (
        .clock(clk), .clear(clear), .enable(enable), .d(d), .count_clear(count_clear),
        .detect(det2), .match_count(cnt2), .saturated(sat2), .fill(fill2));
    pattern_detector #(.PATTERN_WIDTH(3), .PATTERN(3'b101), .OVERLAP(1), .COUNT_WIDTH(2)) u_dut3 (
        .clock(clk), .clear(clear), .enable(enable), .d(d), .count_clear(count_clear),
        .detect(det3), .match_count(cnt3), .saturated(sat3), .fill(fill3));
    pattern_detector #(.PATTERN_WIDTH(4), .PATTERN(4'b1100), .OVERLAP(1), .COUNT_WIDTH(8)) u_dut4 (
        .clock(clk), .clear(clear), .enable(enable), .d(d), .count_clear(count_clear),
        .detect(det4), .match_count(cnt4), .saturated(sat4), .fill(fill4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: compare one expected record per clock edge.
    exp_t m_e;
    logic m_det, m_sat;
    int   m_cnt, m_fill;

    always @(posedge clk) begin
        #1;
        if (q.size() > 0) begin
            m_e = q.pop_front();
            case (m_e.id)
                0: begin m_det = det0; m_cnt = int'(cnt0); m_sat = sat0; m_fill = int'(fill0); end
                1: begin m_det = det1; m_cnt = int'(cnt1); m_sat = sat1; m_fill = int'(fill1); end
                2: begin m_det = det2; m_cnt = int'(cnt2); m_sat = sat2; m_fill = int'(fill2); end
                3: begin m_det = det3; m_cnt = int'(cnt3); m_sat = sat3; m_fill = int'(fill3); end
                default: begin m_det = det4; m_cnt = int'(cnt4); m_sat = sat4; m_fill = int'(fill4); end
            endcase
            checks = checks + 4;
            if (m_det !== m_e.det) begin
                errors++;
                $display("FAIL %s dut%0d detect: got %0b expected %0b", m_e.tag, m_e.id, m_det, m_e.det);
            end
            if (m_cnt !== m_e.cnt) begin
                errors++;
                $display("FAIL %s dut%0d match_count: got %0d expected %0d", m_e.tag, m_e.id, m_cnt, m_e.cnt);
            end
            if (m_sat !== m_e.sat) begin
                errors++;
                $display("FAIL %s dut%0d saturated: got %0b expected %0b", m_e.tag, m_e.id, m_sat, m_e.sat);
            end
            if (m_fill !== m_e.fill) begin
                errors++;
                $display("FAIL %s dut%0d fill: got %0d expected %0d", m_e.tag, m_e.id, m_fill, m_e.fill);
            end
            $display("txn %s dut%0d det=%0b cnt=%0d sat=%0b fill=%0d", m_e.tag, m_e.id, m_det, m_cnt, m_sat, m_fill);
        end
    end

    task automatic step(input logic clr, input logic en, input logic din, input logic cc,
                        input int id, input logic edet, input int ecnt, input logic esat,
                        input int efill, input string tag);
        exp_t e;
        @(negedge clk);
        clear       = clr;
        enable      = en;
        d           = din;
        count_clear = cc;
        e.id   = id;
        e.det  = edet;
        e.cnt  = ecnt;
        e.sat  = esat;
        e.fill = efill;
        e.tag  = tag;
        q.push_back(e);
    endtask

    initial begin
        clear = 1'b1; enable = 1'b0; d = 1'b0; count_clear = 1'b0;

        // Overlapping 1,0,1,0,1
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, "A_reset");
        step(0, 1, 1, 0, 0, 0, 0, 0, 1, "A_b1");
        step(0, 1, 0, 0, 0, 0, 0, 0, 2, "A_b2");
        step(0, 1, 1, 0, 0, 1, 1, 0, 3, "A_b3");
        step(0, 1, 0, 0, 0, 0, 1, 0, 3, "A_b4");
        step(0, 1, 1, 0, 0, 1, 2, 0, 3, "A_b5");
        step(0, 0, 0, 0, 0, 0, 2, 0, 3, "A_idle");

        // Enable gaps between pattern bits
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, "G_reset");
        step(0, 1, 1, 0, 0, 0, 0, 0, 1, "G_b1");
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, "G_gap1");
        step(0, 0, 1, 0, 0, 0, 0, 0, 1, "G_gap2");
        step(0, 1, 0, 0, 0, 0, 0, 0, 2, "G_b2");
        step(0, 0, 1, 0, 0, 0, 0, 0, 2, "G_gap3");
        step(0, 1, 1, 0, 0, 1, 1, 0, 3, "G_b3");
        step(0, 0, 0, 0, 0, 0, 1, 0, 3, "G_after");

        // Clear mid-pattern, then count_clear with and without a match
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, "M_reset");
        step(0, 1, 1, 0, 0, 0, 0, 0, 1, "M_b1");
        step(0, 1, 0, 0, 0, 0, 0, 0, 2, "M_b2");
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, "M_clear");
        step(0, 1, 1, 0, 0, 0, 0, 0, 1, "M_c1");
        step(0, 1, 0, 0, 0, 0, 0, 0, 2, "M_c2");
        step(0, 1, 1, 0, 0, 1, 1, 0, 3, "M_c3");
        step(0, 0, 0, 1, 0, 0, 0, 0, 3, "M_ccl");
        step(0, 1, 0, 0, 0, 0, 0, 0, 3, "M_c4");
        step(0, 1, 1, 1, 0, 1, 1, 0, 3, "M_ccl_match");

        // Non-overlapping 1,0,1,0,1,0,1
        step(1, 0, 0, 0, 1, 0, 0, 0, 0, "B_reset");
        step(0, 1, 1, 0, 1, 0, 0, 0, 1, "B_b1");
        step(0, 1, 0, 0, 1, 0, 0, 0, 2, "B_b2");
        step(0, 1, 1, 0, 1, 1, 1, 0, 0, "B_b3");
        step(0, 1, 0, 0, 1, 0, 1, 0, 1, "B_b4");
        step(0, 1, 1, 0, 1, 0, 1, 0, 2, "B_b5");
        step(0, 1, 0, 0, 1, 0, 1, 0, 3, "B_b6");
        step(0, 1, 1, 0, 1, 1, 2, 0, 0, "B_b7");

        // All-zero pattern must not match on reset history
        step(1, 0, 0, 0, 2, 0, 0, 0, 0, "C_reset");
        step(0, 1, 0, 0, 2, 0, 0, 0, 1, "C_b1");
        step(0, 1, 0, 0, 2, 0, 0, 0, 2, "C_b2");
        step(0, 1, 0, 0, 2, 1, 1, 0, 3, "C_b3");
        step(0, 1, 0, 0, 2, 1, 2, 0, 3, "C_b4");

        // 2-bit saturating count
        step(1, 0, 0, 0, 3, 0, 0, 0, 0, "D_reset");
        step(0, 1, 1, 0, 3, 0, 0, 0, 1, "D_b1");
        step(0, 1, 0, 0, 3, 0, 0, 0, 2, "D_b2");
        step(0, 1, 1, 0, 3, 1, 1, 0, 3, "D_b3");
        step(0, 1, 0, 0, 3, 0, 1, 0, 3, "D_b4");
        step(0, 1, 1, 0, 3, 1, 2, 0, 3, "D_b5");
        step(0, 1, 0, 0, 3, 0, 2, 0, 3, "D_b6");
        step(0, 1, 1, 0, 3, 1, 3, 1, 3, "D_b7");
        step(0, 1, 0, 0, 3, 0, 3, 1, 3, "D_b8");
        step(0, 1, 1, 0, 3, 1, 3, 1, 3, "D_b9");
        step(0, 1, 0, 0, 3, 0, 3, 1, 3, "D_b10");
        step(0, 1, 1, 1, 3, 1, 1, 0, 3, "D_ccl_match");
        step(0, 1, 0, 0, 3, 0, 1, 0, 3, "D_b12");
        step(0, 1, 1, 0, 3, 1, 2, 0, 3, "D_b13");
        step(0, 1, 0, 1, 3, 0, 0, 0, 3, "D_ccl_nomatch");
        step(1, 1, 1, 1, 3, 0, 0, 0, 0, "D_clr_override");

        // 4-bit asymmetric pattern 1100 (first bit is MSB)
        step(1, 0, 0, 0, 4, 0, 0, 0, 0, "E_reset");
        step(0, 1, 0, 0, 4, 0, 0, 0, 1, "E_b1");
        step(0, 1, 0, 0, 4, 0, 0, 0, 2, "E_b2");
        step(0, 1, 1, 0, 4, 0, 0, 0, 3, "E_b3");
        step(0, 1, 1, 0, 4, 0, 0, 0, 4, "E_b4");
        step(0, 1, 0, 0, 4, 0, 0, 0, 4, "E_b5");
        step(0, 1, 0, 0, 4, 1, 1, 0, 4, "E_b6");
        step(0, 1, 1, 0, 4, 0, 1, 0, 4, "E_b7");

        @(negedge clk);
        clear = 1'b0; enable = 1'b0; d = 1'b0; count_clear = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending records, expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
